// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one combinational ALU, with a single registered result stage.
// Define ZCRV_ALU_ARB_FIXED_PRIO_EN for strict port-0 priority instead of round robin.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | result register empty, grant allowed
// ST_FULL  | result register holds an unaccepted result
module alu_arbiter #(
  parameter int XLEN   = 32,
  parameter int IMM_W  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [25:0]                   req_op,
  input  logic [2*(2*XLEN+IMM_W)-1:0]   req_opnd,
  input  logic [2*ADDR_W-1:0]           req_pc,
  output logic [11:0]                   alu_info,
  output logic                          alu_imm_en,
  output logic                          alu_need,
  output logic [XLEN-1:0]               alu_rs1,
  output logic [XLEN-1:0]               alu_rs2,
  output logic [IMM_W-1:0]              alu_imm,
  output logic [ADDR_W-1:0]             alu_pc,
  input  logic [XLEN-1:0]               alu_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [XLEN-1:0]               rsp_data,
  output logic                          rsp_src
);

  localparam int OPW = 2*XLEN + IMM_W;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_rsp_data;
  logic              r_rsp_src;

  logic              w_can_issue;
  logic              w_grant;
  logic              w_win;
  logic [12:0]       w_op;
  logic [OPW-1:0]    w_opnd;
  logic [ADDR_W-1:0] w_pc;

  assign w_can_issue = (r_state == ST_EMPTY) || rsp_ready;
  assign w_grant     = w_can_issue && (req_valid != 2'b00);

`ifdef ZCRV_ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win = ~req_valid[0];
  end
`else
  logic r_last_grant;

  // Round robin: on a tie the port that did not win last time goes next.
  always_comb begin
    w_win = 1'b0;
    case (req_valid)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last_grant;
      default: w_win = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_grant) begin
      r_last_grant <= w_win;
    end
  end
`endif

  assign req_ready = w_grant ? (w_win ? 2'b10 : 2'b01) : 2'b00;

  assign w_op   = w_win ? req_op[25:13]           : req_op[12:0];
  assign w_opnd = w_win ? req_opnd[2*OPW-1:OPW]   : req_opnd[OPW-1:0];
  assign w_pc   = w_win ? req_pc[2*ADDR_W-1:ADDR_W] : req_pc[ADDR_W-1:0];

  // ALU inputs are forced to zero outside grant cycles so alu_result is 0 too.
  assign alu_need   = w_grant;
  assign alu_imm_en = w_grant & w_op[12];
  assign alu_info   = w_grant ? w_op[11:0]                  : '0;
  assign alu_rs1    = w_grant ? w_opnd[OPW-1 -: XLEN]       : '0;
  assign alu_rs2    = w_grant ? w_opnd[IMM_W +: XLEN]       : '0;
  assign alu_imm    = w_grant ? w_opnd[IMM_W-1:0]           : '0;
  assign alu_pc     = w_grant ? w_pc                        : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_rsp_data <= '0;
      r_rsp_src  <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_grant) begin
            r_state    <= ST_FULL;
            r_rsp_data <= alu_result;
            r_rsp_src  <= w_win;
          end
        end
        ST_FULL: begin
          if (w_grant) begin
            r_rsp_data <= alu_result;
            r_rsp_src  <= w_win;
          end else if (rsp_ready) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_data  = r_rsp_data;
  assign rsp_src   = r_rsp_src;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU (ADD/SUB/AUIPC).
// Expected grant order follows ZCRV_ALU_ARB_FIXED_PRIO_EN when defined.
module tb_alu_arbiter;

  localparam int XLEN   = 32;
  localparam int IMM_W  = 32;
  localparam int ADDR_W = 32;

  logic                        clk;
  logic                        rst_n;
  logic [1:0]                  req_valid;
  logic [1:0]                  req_ready;
  logic [25:0]                 req_op;
  logic [2*(2*XLEN+IMM_W)-1:0] req_opnd;
  logic [2*ADDR_W-1:0]         req_pc;
  logic [11:0]                 alu_info;
  logic                        alu_imm_en;
  logic                        alu_need;
  logic [XLEN-1:0]             alu_rs1;
  logic [XLEN-1:0]             alu_rs2;
  logic [IMM_W-1:0]            alu_imm;
  logic [ADDR_W-1:0]           alu_pc;
  logic [XLEN-1:0]             alu_result;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [XLEN-1:0]             rsp_data;
  logic                        rsp_src;

  logic [11:0]       p_info  [2];
  logic              p_immen [2];
  logic [XLEN-1:0]   p_rs1   [2];
  logic [XLEN-1:0]   p_rs2   [2];
  logic [IMM_W-1:0]  p_imm   [2];
  logic [ADDR_W-1:0] p_pc    [2];

  int n_checks = 0;
  int n_errors = 0;

  assign req_op   = {p_immen[1], p_info[1], p_immen[0], p_info[0]};
  assign req_opnd = {p_rs1[1], p_rs2[1], p_imm[1], p_rs1[0], p_rs2[0], p_imm[0]};
  assign req_pc   = {p_pc[1], p_pc[0]};

  always_comb begin
    alu_result = '0;
    if (alu_info[11])      alu_result = alu_rs1 + alu_rs2;
    else if (alu_info[10]) alu_result = alu_rs1 - alu_rs2;
    else if (alu_info[0])  alu_result = alu_pc + (alu_imm_en ? alu_imm : '0);
  end

  alu_arbiter #(.XLEN(XLEN), .IMM_W(IMM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_opnd(req_opnd), .req_pc(req_pc),
    .alu_info(alu_info), .alu_imm_en(alu_imm_en), .alu_need(alu_need),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_src(rsp_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [11:0] info, input logic immen,
                          input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                          input logic [IMM_W-1:0] imm, input logic [ADDR_W-1:0] pc);
    p_info[p]  = info;
    p_immen[p] = immen;
    p_rs1[p]   = rs1;
    p_rs2[p]   = rs2;
    p_imm[p]   = imm;
    p_pc[p]    = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_win;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    set_port(0, 12'h000, 1'b0, '0, '0, '0, '0);
    set_port(1, 12'h000, 1'b0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #3;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_src", rsp_src, 0);
    check("reset_req_ready", req_ready, 0);
    rst_n = 1'b1;
    tick();

    // ADD on port 0, SUB on port 1; port 0 wins the first tie.
    set_port(0, 12'h800, 1'b0, 32'd5, 32'd3, '0, '0);
    set_port(1, 12'h400, 1'b0, 32'd10, 32'd4, '0, '0);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    check("t1_req_ready", req_ready, 2'b01);
    check("t1_alu_need", alu_need, 1);
    check("t1_alu_info", alu_info, 12'h800);
    check("t1_alu_rs1", alu_rs1, 5);
    check("t1_alu_rs2", alu_rs2, 3);
    tick();
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_data", rsp_data, 8);
    check("t1_rsp_src", rsp_src, 0);

    // Stall: result 8 held while consumer is not ready.
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    #1;
    check("t2_stall_ready", req_ready, 2'b00);
    check("t2_stall_need", alu_need, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_valid", rsp_valid, 1);
      check("t2_hold_data", rsp_data, 8);
      check("t2_hold_src", rsp_src, 0);
      check("t2_hold_ready", req_ready, 2'b00);
    end
    rsp_ready = 1'b1;
    #1;
    check("t2_release_ready", req_ready, 2'b10);
    check("t2_release_rs1", alu_rs1, 10);
    tick();
    check("t2_rsp_data", rsp_data, 6);
    check("t2_rsp_src", rsp_src, 1);

    // AUIPC on port 1.
    set_port(1, 12'h001, 1'b1, '0, '0, 32'h0000_1000, 32'h8000_0000);
    req_valid = 2'b10;
    #1;
    check("t3_req_ready", req_ready, 2'b10);
    check("t3_alu_imm_en", alu_imm_en, 1);
    check("t3_alu_imm", alu_imm, 32'h0000_1000);
    check("t3_alu_pc", alu_pc, 32'h8000_0000);
    tick();
    check("t3_rsp_data", rsp_data, 32'h8000_1000);
    check("t3_rsp_src", rsp_src, 1);

    // Both valid for six cycles.
    set_port(0, 12'h800, 1'b0, 32'd1, 32'd2, '0, '0);
    set_port(1, 12'h400, 1'b0, 32'd9, 32'd4, '0, '0);
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
`ifdef ZCRV_ALU_ARB_FIXED_PRIO_EN
      exp_win = 1'b0;
`else
      exp_win = (i % 2) == 1;
`endif
      #1;
      check("t4_req_ready", req_ready, exp_win ? 2'b10 : 2'b01);
      tick();
      check("t4_rsp_data", rsp_data, exp_win ? 5 : 3);
      check("t4_rsp_src", rsp_src, exp_win);
    end

    // Idle: ALU inputs zero, held result drains once accepted.
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    #1;
    check("t6_req_ready", req_ready, 2'b00);
    check("t6_alu_need", alu_need, 0);
    check("t6_alu_info", alu_info, 0);
    check("t6_alu_imm_en", alu_imm_en, 0);
    check("t6_alu_rs1", alu_rs1, 0);
    check("t6_alu_rs2", alu_rs2, 0);
    check("t6_alu_imm", alu_imm, 0);
    check("t6_alu_pc", alu_pc, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_held_valid", rsp_valid, 1);
      check("t6_idle_need", alu_need, 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("t6_drained", rsp_valid, 0);
    tick();
    check("t6_empty_ready_ignored", rsp_valid, 0);

    // Asynchronous reset with a held result; port 0 was the last winner.
    set_port(0, 12'h800, 1'b0, 32'd7, 32'd7, '0, '0);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    tick();
    check("t5_pre_valid", rsp_valid, 1);
    check("t5_pre_data", rsp_data, 14);
    req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", rsp_valid, 0);
    check("t5_async_data", rsp_data, 0);
    check("t5_async_src", rsp_src, 0);
    set_port(0, 12'h800, 1'b0, 32'd1, 32'd2, '0, '0);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #3;
    rst_n = 1'b1;
    #1;
    check("t5_first_grant", req_ready, 2'b01);
    tick();
    check("t5_rsp_data", rsp_data, 3);
    check("t5_rsp_src", rsp_src, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
